axis_register_slice: RTL and testbench

- Fully registered AXI-Stream-style pipeline stage: registers the forward path (out_valid, out_data) and the backward path (in_ready).
- Complements the ready-only skid buffer. That buffer breaks only the ready timing path; this block breaks every combinational path between its two ports.
- Sustains one beat per cycle with 1-cycle latency, using a 2-entry store (main + skid).
- Placed at module boundaries and long routes on stream interfaces.

---
 rtl/axis_register_slice.sv | 102 ++++++++++
 tb/tb_axis_register_slice.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/axis_register_slice.sv
// Fully registered stream pipeline stage: valid, data and ready are all driven from flops,
// with a main + skid store so one beat per cycle is sustained at 1-cycle latency.
//
// state | meaning
// EMPTY | nothing held; in_ready=1 (after the first post-reset cycle), out_valid=0
// BUSY  | one beat in main; in_ready=1, out_valid=1
// FULL  | main and skid both hold beats; in_ready=0, out_valid=1
module axis_register_slice #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [1:0]            r_level;

  logic w_in_xfer;
  logic w_out_xfer;

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // in_ready resets low and only rises on the first clean edge, giving one dead cycle after reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_level     <= 2'd0;
    end else begin
      case (r_state)
        EMPTY: begin
          r_in_ready <= 1'b1;
          if (w_in_xfer) begin
            r_main      <= in_data;
            r_state     <= BUSY;
            r_out_valid <= 1'b1;
            r_level     <= 2'd1;
          end
        end

        BUSY: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main <= in_data;
          end else if (w_in_xfer) begin
            r_skid     <= in_data;
            r_state    <= FULL;
            r_in_ready <= 1'b0;
            r_level    <= 2'd2;
          end else if (w_out_xfer) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_level     <= 2'd0;
          end
        end

        FULL: begin
          // in_ready is low here, so only the downstream side can move
          if (w_out_xfer) begin
            r_main     <= r_skid;
            r_state    <= BUSY;
            r_in_ready <= 1'b1;
            r_level    <= 2'd1;
          end
        end

        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_level     <= 2'd0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign level     = r_level;

endmodule

// File: tb/tb_axis_register_slice.sv
// Directed and random bench for axis_register_slice; a queue-based reference model
// predicts valid/ready/level/data after every edge.
module tb_axis_register_slice;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [1:0]   level;

  axis_register_slice #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level)
  );

  always #5 clk = ~clk;

  int           n_total = 0;
  int           n_bad = 0;
  logic [W-1:0] m_q[$];
  logic         m_rdy = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge, update the model from the inputs seen at that edge, then check all outputs.
  task automatic step();
    logic         xin;
    logic         xout;
    logic         rst_at_edge;
    logic [W-1:0] d;
    xin         = in_valid && m_rdy;
    xout        = (m_q.size() != 0) && out_ready;
    d           = in_data;
    rst_at_edge = !resetn;
    @(posedge clk);
    #1;
    if (rst_at_edge) begin
      m_q.delete();
      m_rdy = 1'b0;
    end else begin
      if (xout) void'(m_q.pop_front());
      if (xin) m_q.push_back(d);
      m_rdy = (m_q.size() != 2);
    end
    chk("out_valid", W'(out_valid), W'(m_q.size() != 0));
    chk("in_ready", W'(in_ready), W'(m_rdy));
    chk("level", W'(level), W'(m_q.size()));
    if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
  endtask

  initial begin
    // reset held 3 cycles with in_valid asserted
    resetn   = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    out_ready = 1'b0;
    repeat (3) begin
      step();
      chk("rst_in_ready", W'(in_ready), 32'd0);
      chk("rst_level", W'(level), 32'd0);
    end
    chk("rst_out_data", out_data, 32'd0);
    resetn   = 1'b1;
    in_valid = 1'b0;
    step();
    chk("post_rst_ready", W'(in_ready), 32'd1);
    chk("post_rst_valid", W'(out_valid), 32'd0);

    // streaming 0x01..0x10
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_data  = W'(i);
      in_valid = 1'b1;
      step();
      chk("stream_data", out_data, W'(i));
      chk("stream_level", W'(level), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drained", W'(out_valid), 32'd0);

    // fill and drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA1;
    step();
    in_data = 32'hA2;
    step();
    in_data = 32'hA3;
    step();
    chk("fill_level", W'(level), 32'd2);
    chk("fill_ready", W'(in_ready), 32'd0);
    chk("fill_data", out_data, 32'hA1);
    step();
    chk("fill_stable", out_data, 32'hA1);
    out_ready = 1'b1;
    step();
    chk("drain_a2", out_data, 32'hA2);
    chk("drain_ready", W'(in_ready), 32'd1);
    step();
    chk("drain_a3", out_data, 32'hA3);
    in_valid = 1'b0;
    step();
    chk("drain_empty", W'(out_valid), 32'd0);

    // simultaneous in/out transfer in BUSY
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    step();
    in_data   = 32'h7E;
    out_ready = 1'b1;
    step();
    chk("simul_data", out_data, 32'h7E);
    chk("simul_level", W'(level), 32'd1);
    in_valid = 1'b0;
    step();

    // reset while full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    step();
    in_data = 32'h66;
    step();
    chk("mid_full", W'(level), 32'd2);
    in_valid = 1'b0;
    resetn   = 1'b0;
    step();
    chk("mid_rst_valid", W'(out_valid), 32'd0);
    chk("mid_rst_level", W'(level), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    resetn    = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      step();
      chk("mid_rst_gone", W'(out_valid), 32'd0);
    end

    // random stress
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
